// File: rtl/mips_rst_pkg.sv
// Shared types and constants for the MIPS reset sequencer.
package mips_rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_EXT  = 2'b00;
  localparam logic [1:0] CAUSE_SOFT = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;

endpackage

// File: rtl/mips_rst_timer.sv
// Clearable up-counter with a terminal-count flag (tc is high while cnt == term).
module mips_rst_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc = (cnt_reg == term);

endmodule

// File: rtl/mips_reset_sequencer.sv
// Staggered reset sequencer for the MIPS core with soft-reset requests and cause reporting.
// Optional watchdog enabled by defining MIPS_RST_WATCHDOG_EN.
module mips_reset_sequencer
  import mips_rst_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_WIDTH      = 8,
  parameter int WDT_CYCLES     = 1024,
  parameter int WDT_WIDTH      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_rst_req,
  output logic              soft_rst_ack,
  input  logic              wdt_kick,
  output logic [NUM_CH-1:0] ch_reset,
  output logic              ch_ready,
  output logic              seq_busy,
  output logic [1:0]        rst_cause
);

  localparam int MAX_PHASE = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;

  if (NUM_CH < 1 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1) begin : g_bad_cfg
    $error("mips_reset_sequencer: NUM_CH, HOLD_CYCLES and STAGGER_CYCLES must be >= 1");
  end
  if (MAX_PHASE > (2 ** CNT_WIDTH) - 1) begin : g_bad_cnt
    $error("mips_reset_sequencer: CNT_WIDTH too small for HOLD/STAGGER cycles");
  end
  if (WDT_CYCLES < 2 || WDT_CYCLES > (2 ** WDT_WIDTH) - 1) begin : g_bad_wdt
    $error("mips_reset_sequencer: WDT_WIDTH too small for WDT_CYCLES");
  end

  localparam logic [CNT_WIDTH-1:0] HOLD_TC = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAG_TC = CNT_WIDTH'(STAGGER_CYCLES - 1);

  state_t              state_reg;
  logic [NUM_CH-1:0]   ch_reset_reg;
  logic [NUM_CH-1:0]   ch_shift;
  logic                ch_ready_reg;
  logic                seq_busy_reg;
  logic                ack_reg;
  logic [1:0]          cause_reg;
  logic                phase_tc;
  logic                phase_clr;
  logic                phase_en;
  logic [CNT_WIDTH-1:0] phase_term;
  logic                wdt_fire;

  // Channels release LSB first, so the next release pattern is a zero-filling left shift;
  // an all-zero result means the last channel is about to drop.
  assign ch_shift   = ch_reset_reg << 1;
  assign phase_term = (state_reg == HOLD) ? HOLD_TC : STAG_TC;
  assign phase_en   = (state_reg != RUN);
  assign phase_clr  = soft_rst_req | wdt_fire | phase_tc | (state_reg == RUN);

  mips_rst_timer #(
    .WIDTH (CNT_WIDTH)
  ) u_phase_timer (
    .clk  (clk),
    .srst (reset),
    .clr  (phase_clr),
    .en   (phase_en),
    .term (phase_term),
    .tc   (phase_tc)
  );

`ifdef MIPS_RST_WATCHDOG_EN
  logic wdt_tc;
  logic wdt_clr;

  assign wdt_clr  = (state_reg != RUN) | wdt_kick | soft_rst_req | wdt_fire;
  // A kick on the timeout edge wins over the watchdog reset.
  assign wdt_fire = (state_reg == RUN) & wdt_tc & ~wdt_kick;

  mips_rst_timer #(
    .WIDTH (WDT_WIDTH)
  ) u_wdt_timer (
    .clk  (clk),
    .srst (reset),
    .clr  (wdt_clr),
    .en   (1'b1),
    .term (WDT_WIDTH'(WDT_CYCLES - 1)),
    .tc   (wdt_tc)
  );
`else
  wire [WDT_WIDTH-1:0] unused_wdt = WDT_WIDTH'(WDT_CYCLES) ^ {WDT_WIDTH{wdt_kick}};
  assign wdt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= HOLD;
      ch_reset_reg <= '1;
      ch_ready_reg <= 1'b0;
      seq_busy_reg <= 1'b1;
      ack_reg      <= 1'b0;
      cause_reg    <= CAUSE_EXT;
    end else if (soft_rst_req) begin
      state_reg    <= HOLD;
      ch_reset_reg <= '1;
      ch_ready_reg <= 1'b0;
      seq_busy_reg <= 1'b1;
      ack_reg      <= 1'b1;
      cause_reg    <= CAUSE_SOFT;
    end else if (wdt_fire) begin
      state_reg    <= HOLD;
      ch_reset_reg <= '1;
      ch_ready_reg <= 1'b0;
      seq_busy_reg <= 1'b1;
      ack_reg      <= 1'b0;
      cause_reg    <= CAUSE_WDT;
    end else begin
      ack_reg <= 1'b0;
      case (state_reg)
        HOLD, RELEASE: begin
          if (phase_tc) begin
            ch_reset_reg <= ch_shift;
            if (ch_shift == '0) begin
              state_reg    <= RUN;
              ch_ready_reg <= 1'b1;
              seq_busy_reg <= 1'b0;
            end else begin
              state_reg <= RELEASE;
            end
          end
        end
        RUN: begin
          state_reg <= RUN;
        end
        default: begin
          state_reg    <= HOLD;
          ch_reset_reg <= '1;
          ch_ready_reg <= 1'b0;
          seq_busy_reg <= 1'b1;
        end
      endcase
    end
  end

  assign ch_reset     = ch_reset_reg;
  assign ch_ready     = ch_ready_reg;
  assign seq_busy     = seq_busy_reg;
  assign soft_rst_ack = ack_reg;
  assign rst_cause    = cause_reg;

endmodule

// File: tb/tb_mips_reset_sequencer.sv
// Self-checking bench for mips_reset_sequencer: directed scenarios plus random stimulus vs an edge-count model.
module tb_mips_reset_sequencer;

  localparam int NUM_CH = 4;
  localparam int HOLD   = 8;
  localparam int STAG   = 4;
  localparam int WDT    = 16;
  localparam int RUN_N  = HOLD + (NUM_CH - 1) * STAG;

  logic              clk = 1'b0;
  logic              reset;
  logic              soft_rst_req;
  logic              wdt_kick;
  logic              soft_rst_ack;
  logic [NUM_CH-1:0] ch_reset;
  logic              ch_ready;
  logic              seq_busy;
  logic [1:0]        rst_cause;

  mips_reset_sequencer #(
    .NUM_CH         (NUM_CH),
    .HOLD_CYCLES    (HOLD),
    .STAGGER_CYCLES (STAG),
    .CNT_WIDTH      (8),
    .WDT_CYCLES     (WDT),
    .WDT_WIDTH      (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .soft_rst_req (soft_rst_req),
    .soft_rst_ack (soft_rst_ack),
    .wdt_kick     (wdt_kick),
    .ch_reset     (ch_reset),
    .ch_ready     (ch_ready),
    .seq_busy     (seq_busy),
    .rst_cause    (rst_cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: n = edges since the last sequence start, w = watchdog count in RUN.
  int         n = 0;
  int         w = 0;
  logic [1:0] m_cause = 2'b00;
  logic       m_ack = 1'b0;
  int         txn = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic kick_i);
    logic              was_run;
    logic              fire;
    logic [NUM_CH-1:0] exp_ch;
    reset        = r;
    soft_rst_req = s;
    wdt_kick     = kick_i;
    @(posedge clk);
    was_run = (n >= RUN_N);
    fire    = 1'b0;
`ifdef MIPS_RST_WATCHDOG_EN
    fire = was_run && (w == WDT - 1) && !kick_i;
`endif
    if (r) begin
      n = 0; m_cause = 2'b00; m_ack = 1'b0;
    end else if (s) begin
      n = 0; m_cause = 2'b01; m_ack = 1'b1;
    end else if (fire) begin
      n = 0; m_cause = 2'b10; m_ack = 1'b0;
    end else begin
      if (n < RUN_N) n = n + 1;
      m_ack = 1'b0;
    end
    if (r || s || fire || !was_run || kick_i) w = 0;
    else w = w + 1;
    @(negedge clk);
    for (int k = 0; k < NUM_CH; k++) exp_ch[k] = (n < HOLD + k * STAG);
    check("ch_reset", 32'(ch_reset), 32'(exp_ch));
    check("ch_ready", 32'(ch_ready), 32'(n >= RUN_N));
    check("seq_busy", 32'(seq_busy), 32'(n < RUN_N));
    check("soft_rst_ack", 32'(soft_rst_ack), 32'(m_ack));
    check("rst_cause", 32'(rst_cause), 32'(m_cause));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic note(input string what);
    txn++;
    $display("txn %0d: %s (checks=%0d errors=%0d)", txn, what, checks, errors);
  endtask

  initial begin
    reset        = 1'b1;
    soft_rst_req = 1'b0;
    wdt_kick     = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    idle(25);
    note("external reset then staggered release");

    step(1'b0, 1'b1, 1'b0);
    idle(25);
    note("single-cycle soft request in RUN");

    step(1'b0, 1'b1, 1'b0);
    idle(10);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    idle(25);
    note("soft request held 5 cycles during RELEASE");

    step(1'b1, 1'b0, 1'b0);
    idle(13);
    step(1'b1, 1'b0, 1'b0);
    idle(25);
    note("reset at edge 14 restarts sequence");

    step(1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(25);
    note("reset and soft request together");

`ifdef MIPS_RST_WATCHDOG_EN
    step(1'b1, 1'b0, 1'b0);
    idle(RUN_N + 40);
    note("watchdog timeout without kicks");

    step(1'b1, 1'b0, 1'b0);
    idle(RUN_N + 2);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, (i % 10) == 9);
      check("wdt_kick_ready", 32'(ch_ready), 32'd1);
    end
    note("watchdog kicked every 10 cycles");
`endif

    for (int i = 0; i < 1500; i++) begin
      logic r;
      logic s;
      logic kk;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 59) == 0) || (soft_rst_req && $urandom_range(0, 2) == 0);
      kk = ($urandom_range(0, 11) == 0);
      step(r, s, kk);
    end
    note("random reset/soft/kick stimulus");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
